bulk_ep_router: RTL

//  N-channel bulk endpoint router in the usb_clk domain, between usb_tlp's blk_xfer_* port and N per-endpoint FIFOs.

---
 rtl/bulk_ep_pkg.sv | 16 +
 rtl/bulk_ep_pkt_limit.sv | 33 +++
 rtl/bulk_ep_router.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bulk_ep_pkg.sv
// Shared constants and FSM encoding for the bulk endpoint router.
package bulk_ep_pkg;

  localparam int MAX_PKT_HS = 512;  // high-speed bulk max packet size
  localparam int MAX_PKT_FS = 64;   // full-speed bulk max packet size
  localparam int PKT_CNT_W  = 10;   // byte counter width, covers 0..MAX_PKT_HS
  localparam int STAT_W     = 16;   // per-channel packet counter width

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_XFER  = 2'd1,
    ST_OUT_XFER = 2'd2,
    ST_DRAIN    = 2'd3
  } state_t;

endpackage

// File: rtl/bulk_ep_pkt_limit.sv
// Per-direction packet byte counter with a terminal-count compare.
// o_limit rises once LIMIT bytes have been counted; the counter then holds.
module bulk_ep_pkt_limit
  import bulk_ep_pkg::*;
#(
  parameter int LIMIT = MAX_PKT_HS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_limit
);

  localparam logic [PKT_CNT_W-1:0] LIMIT_CNT = PKT_CNT_W'(LIMIT);

  logic [PKT_CNT_W-1:0] r_count;

  // Count bytes of the current packet, cleared between packets, saturating at LIMIT.
  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_limit) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_limit = (r_count == LIMIT_CNT);

endmodule

// File: rtl/bulk_ep_router.sv
// N-channel bulk endpoint router between the TLP bulk port and per-endpoint FIFOs.
// Channel i serves endpoint EP_BASE+i in both directions. IN is a zero-latency
// pass-through with forced tlast at MAX_PKT; OUT uses a one-byte hold so the
// final byte can be tagged with tlast when the transfer ends.
// Optional: define BULK_EP_ROUTER_STATS_EN to enable per-channel packet counters.
module bulk_ep_router
  import bulk_ep_pkg::*;
#(
  parameter int NUM_CHAN   = 2,
  parameter int EP_BASE    = 1,
  parameter int HIGH_SPEED = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 blk_xfer_endpoint,
  input  logic                       blk_in_xfer,
  input  logic                       blk_out_xfer,
  output logic                       blk_xfer_in_has_data,
  output logic [7:0]                 blk_xfer_in_data,
  output logic                       blk_xfer_in_data_valid,
  input  logic                       blk_xfer_in_data_ready,
  output logic                       blk_xfer_in_data_last,
  output logic                       blk_xfer_out_ready_read,
  input  logic [7:0]                 blk_xfer_out_data,
  input  logic                       blk_xfer_out_data_valid,
  input  logic [NUM_CHAN-1:0]        ch_in_has_data,
  input  logic [8*NUM_CHAN-1:0]      ch_in_tdata,
  input  logic [NUM_CHAN-1:0]        ch_in_tvalid,
  input  logic [NUM_CHAN-1:0]        ch_in_tlast,
  output logic [NUM_CHAN-1:0]        ch_in_tready,
  output logic [NUM_CHAN-1:0]        ch_in_xfer,
  output logic [NUM_CHAN-1:0]        ch_out_xfer,
  input  logic [NUM_CHAN-1:0]        ch_out_ready_read,
  output logic [7:0]                 ch_out_tdata,
  output logic [NUM_CHAN-1:0]        ch_out_tvalid,
  output logic                       ch_out_tlast,
  input  logic [NUM_CHAN-1:0]        ch_out_tready,
  input  logic                       err_clr,
  output logic                       err_oversize,
  output logic                       err_overrun,
  output logic [STAT_W*NUM_CHAN-1:0] stat_in_pkts,
  output logic [STAT_W*NUM_CHAN-1:0] stat_out_pkts
);

  localparam int MAX_PKT = (HIGH_SPEED != 0) ? MAX_PKT_HS : MAX_PKT_FS;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_sel;
  logic                 r_in_done;
  logic [7:0]           r_hold;
  logic                 r_hold_vld;
  logic                 r_err_oversize;
  logic                 r_err_overrun;

  logic [3:0]           w_sel;
  logic                 w_hit;
  logic [NUM_CHAN-1:0]  w_onehot;
  logic [7:0]           w_src_data;
  logic                 w_src_valid;
  logic                 w_src_last;
  logic                 w_sink_ready;
  logic                 w_in_state;
  logic                 w_out_state;
  logic                 w_in_active;
  logic                 w_in_fire;
  logic                 w_in_limit;
  logic                 w_in_exit;
  logic                 w_out_strobe;
  logic                 w_out_accept;
  logic                 w_out_oversize;
  logic                 w_out_end;
  logic                 w_out_emit;
  logic                 w_out_overrun;
  logic                 w_out_limit;

  // Unsigned 4-bit wrap turns endpoints below EP_BASE into large values, i.e. misses.
  assign w_sel = blk_xfer_endpoint - 4'(EP_BASE);
  assign w_hit = (w_sel < 4'(NUM_CHAN));

  // Channel muxes: live-endpoint status lookups and latched-channel data path.
  // NOTE: every signal gets a default before the loop so no path infers a latch.
  always_comb begin
    blk_xfer_in_has_data    = 1'b0;
    blk_xfer_out_ready_read = 1'b0;
    w_onehot                = '0;
    w_src_data              = '0;
    w_src_valid             = 1'b0;
    w_src_last              = 1'b0;
    w_sink_ready            = 1'b0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (w_sel == 4'(i)) begin
        blk_xfer_in_has_data    = ch_in_has_data[i];
        blk_xfer_out_ready_read = ch_out_ready_read[i];
      end
      if (r_sel == 4'(i)) begin
        w_onehot[i]  = 1'b1;
        w_src_data   = ch_in_tdata[8*i +: 8];
        w_src_valid  = ch_in_tvalid[i];
        w_src_last   = ch_in_tlast[i];
        w_sink_ready = ch_out_tready[i];
      end
    end
  end

  // Next-state decode; IN takes priority when both transfer flags rise together.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (blk_in_xfer) begin
          w_next = w_hit ? ST_IN_XFER : ST_DRAIN;
        end else if (blk_out_xfer) begin
          w_next = w_hit ? ST_OUT_XFER : ST_DRAIN;
        end
      end
      ST_IN_XFER:  if (!blk_in_xfer)  w_next = ST_IDLE;
      ST_OUT_XFER: if (!blk_out_xfer) w_next = ST_IDLE;
      ST_DRAIN:    if (!blk_in_xfer && !blk_out_xfer) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Per-state datapath outputs: IN pass-through gating and OUT hold emission.
  always_comb begin
    w_in_state             = (r_state == ST_IN_XFER);
    w_out_state            = (r_state == ST_OUT_XFER);
    w_in_active            = w_in_state && !r_in_done;
    blk_xfer_in_data_valid = w_in_active && w_src_valid;
    blk_xfer_in_data_last  = blk_xfer_in_data_valid && (w_src_last || w_in_limit);
    blk_xfer_in_data       = w_in_state ? w_src_data : 8'h00;
    w_in_fire              = blk_xfer_in_data_valid && blk_xfer_in_data_ready;
    w_in_exit              = w_in_state && !blk_in_xfer;
    ch_in_tready           = (w_in_active && blk_xfer_in_data_ready) ? w_onehot : '0;
    ch_in_xfer             = w_in_state  ? w_onehot : '0;
    ch_out_xfer            = w_out_state ? w_onehot : '0;

    w_out_strobe   = w_out_state && blk_out_xfer && blk_xfer_out_data_valid;
    w_out_accept   = w_out_strobe && !w_out_limit;
    w_out_oversize = w_out_strobe && w_out_limit;
    w_out_end      = w_out_state && !blk_out_xfer;
    // The held byte leaves when a newer byte displaces it or the transfer ends.
    w_out_emit     = r_hold_vld && (w_out_accept || w_out_end);
    ch_out_tvalid  = w_out_emit ? w_onehot : '0;
    ch_out_tdata   = w_out_emit ? r_hold : 8'h00;
    ch_out_tlast   = w_out_emit && w_out_end;
    w_out_overrun  = w_out_emit && !w_sink_ready;
  end

  // IN forces tlast on byte MAX_PKT-1; OUT stops accepting after MAX_PKT bytes.
  bulk_ep_pkt_limit #(.LIMIT(MAX_PKT - 1)) u_in_limit (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!w_in_state),
    .i_inc   (w_in_fire),
    .o_limit (w_in_limit)
  );

  bulk_ep_pkt_limit #(.LIMIT(MAX_PKT)) u_out_limit (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (!w_out_state),
    .i_inc   (w_out_accept),
    .o_limit (w_out_limit)
  );

  // State register; the channel is captured while idle so it is fixed on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE) begin
        r_sel <= w_sel;
      end
    end
  end

  // IN end-of-packet flag: once a last byte is accepted the channel is gated off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_done <= 1'b0;
    end else if (!w_in_state) begin
      r_in_done <= 1'b0;
    end else if (w_in_fire && blk_xfer_in_data_last) begin
      r_in_done <= 1'b1;
    end
  end

  // OUT one-byte hold; emptied when the transfer ends so nothing leaks into the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold     <= 8'h00;
      r_hold_vld <= 1'b0;
    end else if (!w_out_state || w_out_end) begin
      r_hold_vld <= 1'b0;
    end else if (w_out_accept) begin
      r_hold     <= blk_xfer_out_data;
      r_hold_vld <= 1'b1;
    end
  end

  // Sticky error flags; a fresh error in the clear cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_oversize <= 1'b0;
      r_err_overrun  <= 1'b0;
    end else begin
      r_err_oversize <= (r_err_oversize && !err_clr) || w_out_oversize;
      r_err_overrun  <= (r_err_overrun  && !err_clr) || w_out_overrun;
    end
  end

  assign err_oversize = r_err_oversize;
  assign err_overrun  = r_err_overrun;

`ifdef BULK_EP_ROUTER_STATS_EN
  logic [STAT_W-1:0] r_stat_in  [NUM_CHAN];
  logic [STAT_W-1:0] r_stat_out [NUM_CHAN];

  // Count completed packets per channel at transfer exit; DRAIN never reaches here.
  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        r_stat_in[i]  <= '0;
        r_stat_out[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (w_in_exit && w_onehot[i]) begin
          r_stat_in[i] <= r_stat_in[i] + STAT_W'(1);
        end
        if (w_out_end && w_onehot[i]) begin
          r_stat_out[i] <= r_stat_out[i] + STAT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_stat
    assign stat_in_pkts[g*STAT_W +: STAT_W]  = r_stat_in[g];
    assign stat_out_pkts[g*STAT_W +: STAT_W] = r_stat_out[g];
  end
`else
  assign stat_in_pkts  = '0;
  assign stat_out_pkts = '0;
`endif

endmodule
